// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types and defaults for the MIPS unified-memory arbiter.
package mips_mem_pkg;

  localparam int DEF_DEPTH = 1024;
  localparam int DEF_AW    = 10;
  localparam int DEF_DW    = 32;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD
  } state_e;

  // Which requester owns the read data returned one cycle after its grant.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LD,
    SEL_DATA,
    SEL_FETCH
  } port_sel_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the loader / MEM stage / IF stage and the memory arbiter.
interface mips_mem_arbiter_if;
  import mips_mem_pkg::*;

  logic              ld_en;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [DEF_DW-1:0] ld_wdata;
  logic              ld_rvalid;

  logic              d_req;
  logic              d_we;
  logic              d_kill;
  logic [31:0]       d_addr;
  logic [DEF_DW-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;

  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;

  logic              halted;
  logic [DEF_DW-1:0] rdata;
  logic              ready;
  logic              addr_err;

  modport master (
    output ld_en, ld_we, ld_addr, ld_wdata,
    output d_req, d_we, d_kill, d_addr, d_wdata,
    output f_req, f_addr, halted,
    input  ld_rvalid, d_gnt, d_rvalid, f_gnt, f_rvalid, rdata, ready, addr_err
  );

  modport slave (
    input  ld_en, ld_we, ld_addr, ld_wdata,
    input  d_req, d_we, d_kill, d_addr, d_wdata,
    input  f_req, f_addr, halted,
    output ld_rvalid, d_gnt, d_rvalid, f_gnt, f_rvalid, rdata, ready, addr_err
  );

endinterface

// File: rtl/mips_mem_arbiter_sp_ram.sv
// Single-port synchronous RAM with registered, read-before-write output.
module mips_sp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the program loader, MEM-stage data
// port and IF-stage fetch port, with post-reset clearing and fetch starvation guard.
module mips_mem_arbiter #(
  parameter int DEPTH          = mips_mem_pkg::DEF_DEPTH,
  parameter int AW             = mips_mem_pkg::DEF_AW,
  parameter int DW             = mips_mem_pkg::DEF_DW,
  parameter int STARVE_LIMIT   = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic              clk1,
  input logic              rst,
  mips_mem_arbiter_if.slave bus
);
  import mips_mem_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_e        state_q;
  logic [AW-1:0] clr_addr_q;
  logic [CW-1:0] starve_q;
  port_sel_e     sel_q, sel_d;
  logic          err_q;
  logic          ready_q;

  logic          run_free, fetch_want, starved;
  logic          d_gnt, f_gnt;
  logic          acc_valid, acc_we, acc_oob, ram_we;
  logic [31:0]   acc_addr;
  logic [DW-1:0] acc_wdata, ram_rdata;

  always_comb begin
    run_free   = (state_q == ST_RUN) && !bus.ld_en;
    fetch_want = bus.f_req && !bus.halted;
    starved    = (starve_q == CW'(STARVE_LIMIT));
    f_gnt      = run_free && fetch_want && (!bus.d_req || starved);
    d_gnt      = run_free && bus.d_req && !f_gnt;
  end

  // Stores and loader writes never return read data, so they steer no rvalid.
  always_comb begin
    acc_valid = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    sel_d     = SEL_NONE;
    case (state_q)
      ST_CLEAR: begin
        acc_valid = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 32'(clr_addr_q);
      end
      ST_LOAD: begin
        acc_valid = 1'b1;
        acc_we    = bus.ld_we;
        acc_addr  = bus.ld_addr;
        acc_wdata = bus.ld_wdata;
        sel_d     = bus.ld_we ? SEL_NONE : SEL_LD;
      end
      default: begin
        if (d_gnt) begin
          acc_valid = 1'b1;
          acc_we    = bus.d_we && !bus.d_kill;
          acc_addr  = bus.d_addr;
          acc_wdata = bus.d_wdata;
          sel_d     = bus.d_we ? SEL_NONE : SEL_DATA;
        end else if (f_gnt) begin
          acc_valid = 1'b1;
          acc_addr  = bus.f_addr;
          sel_d     = SEL_FETCH;
        end
      end
    endcase
    acc_oob = acc_valid && (acc_addr[31:AW] != '0);
    ram_we  = acc_we && !acc_oob;
  end

  mips_sp_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk_i   (clk1),
    .we_i    (ram_we),
    .addr_i  (acc_addr[AW-1:0]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr_q <= '0;
      starve_q   <= '0;
      sel_q      <= SEL_NONE;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          starve_q <= '0;
          if (!bus.ld_en) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          ready_q <= !bus.ld_en;
          if (bus.ld_en) state_q <= ST_LOAD;
          if (fetch_want && !f_gnt) starve_q <= starved ? starve_q : starve_q + 1'b1;
          else                      starve_q <= '0;
        end
      endcase
      sel_q <= sel_d;
      err_q <= acc_oob;
    end
  end

  assign bus.d_gnt     = d_gnt;
  assign bus.f_gnt     = f_gnt;
  assign bus.addr_err  = acc_oob;
  assign bus.ready     = ready_q;
  assign bus.ld_rvalid = (sel_q == SEL_LD);
  assign bus.d_rvalid  = (sel_q == SEL_DATA);
  assign bus.f_rvalid  = (sel_q == SEL_FETCH);
  assign bus.rdata     = ((sel_q != SEL_NONE) && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed tables, corner sequences, random vs. model.
module tb_mips_mem_arbiter;

  localparam int LIMIT    = 4;
  localparam int MEMDEPTH = 1024;

  typedef struct {
    logic        ldEn, ldWe;
    logic [31:0] ldAddr, ldWdata;
    logic        dReq, dWe, dKill;
    logic [31:0] dAddr, dWdata;
    logic        fReq;
    logic [31:0] fAddr;
    logic        halt;
  } stim_t;

  typedef struct packed {
    logic dReq, fReq, halt, expD, expF;
  } vec_t;

  logic clk1 = 1'b0;
  logic rst;
  mips_mem_arbiter_if bus ();

  mips_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1'b1)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, loader mode, denied-fetch streak, pending read.
  logic [31:0] refMem [MEMDEPTH];
  logic        refLoad;
  int          refStarve;
  int          refPend;
  logic [31:0] refPendData;

  logic        sDGnt, sFGnt, sErr, sDRv, sFRv, sLdRv;
  logic [31:0] sRdata;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.ld_en    = s.ldEn;
    bus.ld_we    = s.ldWe;
    bus.ld_addr  = s.ldAddr;
    bus.ld_wdata = s.ldWdata;
    bus.d_req    = s.dReq;
    bus.d_we     = s.dWe;
    bus.d_kill   = s.dKill;
    bus.d_addr   = s.dAddr;
    bus.d_wdata  = s.dWdata;
    bus.f_req    = s.fReq;
    bus.f_addr   = s.fAddr;
    bus.halted   = s.halt;
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '{ldEn: 1'b0, ldWe: 1'b0, ldAddr: 32'd0, ldWdata: 32'd0,
          dReq: 1'b0, dWe: 1'b0, dKill: 1'b0, dAddr: 32'd0, dWdata: 32'd0,
          fReq: 1'b0, fAddr: 32'd0, halt: 1'b0};
    return s;
  endfunction

  function automatic stim_t ldStim(input logic en, input logic we, input logic [31:0] addr, input logic [31:0] data);
    stim_t s;
    s = idleStim();
    s.ldEn = en;  s.ldWe = we;  s.ldAddr = addr;  s.ldWdata = data;
    s.dReq = 1'b1;  s.dAddr = 32'd7;  s.fReq = 1'b1;  s.fAddr = 32'd8;
    return s;
  endfunction

  function automatic stim_t dStim(input logic we, input logic kill, input logic [31:0] addr, input logic [31:0] data);
    stim_t s;
    s = idleStim();
    s.dReq = 1'b1;  s.dWe = we;  s.dKill = kill;  s.dAddr = addr;  s.dWdata = data;
    return s;
  endfunction

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16)  return 32'(r);
    if (r == 16) return 32'd1023;
    return $urandom() | 32'h0000_0400;
  endfunction

  function automatic logic [31:0] peek(input logic [31:0] addr);
    return (addr >= MEMDEPTH) ? 32'd0 : refMem[addr % MEMDEPTH];
  endfunction

  // One clock cycle: drive, check last cycle's read result and this cycle's grants, advance the model.
  task automatic stepCycle(input stim_t s);
    logic expD, expF, expErr;
    int   pend;
    logic [31:0] pdata;
    @(negedge clk1);
    applyStimulus(s);
    #1;
    sDGnt = bus.d_gnt;  sFGnt = bus.f_gnt;  sErr = bus.addr_err;
    sDRv = bus.d_rvalid;  sFRv = bus.f_rvalid;  sLdRv = bus.ld_rvalid;  sRdata = bus.rdata;
    checkOutput("ld_rvalid", sLdRv, refPend == 1);
    checkOutput("d_rvalid", sDRv, refPend == 2);
    checkOutput("f_rvalid", sFRv, refPend == 3);
    checkOutput("rdata", sRdata, (refPend != 0) ? refPendData : 32'd0);
    expD = 1'b0;  expF = 1'b0;  expErr = 1'b0;  pend = 0;  pdata = 32'd0;
    if (refLoad) begin
      expErr = (s.ldAddr >= MEMDEPTH);
      if (s.ldWe) begin
        if (!expErr) refMem[s.ldAddr % MEMDEPTH] = s.ldWdata;
      end else begin
        pend = 1;  pdata = peek(s.ldAddr);
      end
      refStarve = 0;
      refLoad = s.ldEn;
    end else if (s.ldEn) begin
      refStarve = (s.fReq && !s.halt) ? ((refStarve < LIMIT) ? refStarve + 1 : LIMIT) : 0;
      refLoad = 1'b1;
    end else begin
      expF = s.fReq && !s.halt && (!s.dReq || refStarve >= LIMIT);
      expD = s.dReq && !expF;
      if (expD) begin
        expErr = (s.dAddr >= MEMDEPTH);
        if (s.dWe) begin
          if (!expErr && !s.dKill) refMem[s.dAddr % MEMDEPTH] = s.dWdata;
        end else begin
          pend = 2;  pdata = peek(s.dAddr);
        end
      end else if (expF) begin
        expErr = (s.fAddr >= MEMDEPTH);
        pend = 3;  pdata = peek(s.fAddr);
      end
      refStarve = (s.fReq && !s.halt && !expF) ? ((refStarve < LIMIT) ? refStarve + 1 : LIMIT) : 0;
    end
    checkOutput("d_gnt", sDGnt, expD);
    checkOutput("f_gnt", sFGnt, expF);
    checkOutput("addr_err", sErr, expErr);
    refPend = pend;
    refPendData = pdata;
  endtask

  // Reset for one cycle with the given inputs, then run through CLEAR while both ports request.
  task automatic resetAndClear(input stim_t rstInputs);
    int lowCycles, gntSeen;
    stim_t s;
    @(negedge clk1);
    rst = 1'b1;
    applyStimulus(rstInputs);
    @(negedge clk1);
    rst = 1'b0;
    s = idleStim();
    s.dReq = 1'b1;  s.fReq = 1'b1;  s.dAddr = 32'd3;  s.fAddr = 32'd4;
    applyStimulus(s);
    #1;
    checkOutput("rst_ready", bus.ready, 1'b0);
    checkOutput("rst_d_rvalid", bus.d_rvalid, 1'b0);
    checkOutput("rst_f_rvalid", bus.f_rvalid, 1'b0);
    checkOutput("rst_ld_rvalid", bus.ld_rvalid, 1'b0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_addr_err", bus.addr_err, 1'b0);
    checkOutput("rst_d_gnt", bus.d_gnt, 1'b0);
    checkOutput("rst_f_gnt", bus.f_gnt, 1'b0);
    lowCycles = 0;
    gntSeen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.ready === 1'b1) break;
      if (bus.d_gnt !== 1'b0 || bus.f_gnt !== 1'b0) gntSeen++;
      lowCycles++;
      @(negedge clk1);
      #1;
    end
    applyStimulus(idleStim());
    checkOutput("clear_cycles", 32'(lowCycles), 32'd1024);
    checkOutput("clear_grants", 32'(gntSeen), 32'd0);
    for (int i = 0; i < MEMDEPTH; i++) refMem[i] = 32'd0;
    refLoad = 1'b0;
    refStarve = 0;
    refPend = 0;
    refPendData = 32'd0;
  endtask

  vec_t  vecs [14];
  stim_t st;
  logic  randLd;

  initial begin
    vecs = '{5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b11001, 5'b11010, 5'b01001,
             5'b11010, 5'b10010, 5'b11010, 5'b11110, 5'b01100, 5'b11010, 5'b00000};
    rst = 1'b1;
    applyStimulus(idleStim());
    refLoad = 1'b0;  refStarve = 0;  refPend = 0;  refPendData = 32'd0;

    // First clear, then dirty three words so the second clear has something to erase.
    resetAndClear(idleStim());
    stepCycle(ldStim(1'b1, 1'b0, 32'd0, 32'd0));
    stepCycle(ldStim(1'b1, 1'b1, 32'd0, 32'hDEAD_BEEF));
    stepCycle(ldStim(1'b1, 1'b1, 32'd512, 32'hDEAD_BEEF));
    stepCycle(ldStim(1'b1, 1'b1, 32'd1023, 32'hDEAD_BEEF));
    stepCycle(ldStim(1'b0, 1'b0, 32'd0, 32'd0));
    stepCycle(idleStim());

    resetAndClear(idleStim());
    $display("[TB] loader mode checks");
    stepCycle(ldStim(1'b1, 1'b0, 32'd0, 32'd0));
    checkOutput("ld_entry_d_gnt", sDGnt, 1'b0);
    stepCycle(ldStim(1'b1, 1'b0, 32'd0, 32'd0));
    checkOutput("ld_d_gnt", sDGnt, 1'b0);
    checkOutput("ld_f_gnt", sFGnt, 1'b0);
    stepCycle(ldStim(1'b1, 1'b0, 32'd512, 32'd0));
    checkOutput("clr0_vld", sLdRv, 1'b1);
    checkOutput("clr0_data", sRdata, 32'd0);
    stepCycle(ldStim(1'b1, 1'b0, 32'd1023, 32'd0));
    checkOutput("clr512_data", sRdata, 32'd0);
    stepCycle(ldStim(1'b1, 1'b1, 32'd0, 32'h2801_0078));
    checkOutput("clr1023_vld", sLdRv, 1'b1);
    checkOutput("clr1023_data", sRdata, 32'd0);
    stepCycle(ldStim(1'b1, 1'b1, 32'd121, 32'h0000_0011));
    stepCycle(ldStim(1'b1, 1'b0, 32'd0, 32'd0));
    checkOutput("ld_f_gnt_rd", sFGnt, 1'b0);
    stepCycle(ldStim(1'b0, 1'b0, 32'd1, 32'd0));
    checkOutput("ld_rd_vld", sLdRv, 1'b1);
    checkOutput("ld_rd_data", sRdata, 32'h2801_0078);
    stepCycle(dStim(1'b0, 1'b0, 32'd0, 32'd0));
    checkOutput("first_run_gnt", sDGnt, 1'b1);
    stepCycle(idleStim());
    checkOutput("first_run_data", sRdata, 32'h2801_0078);

    $display("[TB] squashed store checks");
    stepCycle(dStim(1'b1, 1'b1, 32'd121, 32'h82));
    checkOutput("kill_gnt", sDGnt, 1'b1);
    stepCycle(dStim(1'b0, 1'b0, 32'd121, 32'd0));
    stepCycle(dStim(1'b1, 1'b0, 32'd121, 32'h82));
    checkOutput("kill_old_vld", sDRv, 1'b1);
    checkOutput("kill_old_data", sRdata, 32'h11);
    stepCycle(dStim(1'b0, 1'b0, 32'd121, 32'd0));
    stepCycle(idleStim());
    checkOutput("store_new_data", sRdata, 32'h82);

    $display("[TB] out-of-range checks");
    stepCycle(dStim(1'b1, 1'b0, 32'h400, 32'hCAFE_F00D));
    checkOutput("oob_st_err", sErr, 1'b1);
    checkOutput("oob_st_gnt", sDGnt, 1'b1);
    stepCycle(dStim(1'b0, 1'b0, 32'h400, 32'd0));
    checkOutput("oob_ld_err", sErr, 1'b1);
    stepCycle(dStim(1'b0, 1'b0, 32'd0, 32'd0));
    checkOutput("oob_ld_vld", sDRv, 1'b1);
    checkOutput("oob_ld_data", sRdata, 32'd0);
    checkOutput("oob_err_clear", sErr, 1'b0);
    stepCycle(idleStim());
    checkOutput("oob_no_alias", sRdata, 32'h2801_0078);

    $display("[TB] arbitration table");
    stepCycle(idleStim());
    for (int i = 0; i < 14; i++) begin
      st = idleStim();
      st.dReq = vecs[i].dReq;  st.dAddr = 32'd121;
      st.fReq = vecs[i].fReq;  st.fAddr = 32'd0;
      st.halt = vecs[i].halt;
      stepCycle(st);
      checkOutput($sformatf("tbl%0d_d_gnt", i), sDGnt, vecs[i].expD);
      checkOutput($sformatf("tbl%0d_f_gnt", i), sFGnt, vecs[i].expF);
    end

    $display("[TB] random traffic");
    randLd = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 4) randLd = !randLd;
      st = idleStim();
      st.ldEn = randLd;  st.ldWe = 1'($urandom_range(0, 1));
      st.ldAddr = randAddr();  st.ldWdata = $urandom();
      st.dReq = ($urandom_range(0, 3) != 0);  st.dWe = 1'($urandom_range(0, 1));
      st.dKill = ($urandom_range(0, 4) == 0);  st.dAddr = randAddr();  st.dWdata = $urandom();
      st.fReq = ($urandom_range(0, 3) != 0);  st.fAddr = randAddr();
      st.halt = ($urandom_range(0, 7) == 0);
      stepCycle(st);
    end
    stepCycle(idleStim());
    stepCycle(idleStim());
    checkOutput("run_ready", bus.ready, 1'b1);

    $display("[TB] reset during granted read");
    resetAndClear(dStim(1'b0, 1'b0, 32'd121, 32'd0));
    stepCycle(dStim(1'b0, 1'b0, 32'd121, 32'd0));
    stepCycle(idleStim());
    checkOutput("post_rst_data", sRdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory controller that shares the 1024 x 32 unified program/data memory of the pipelined MIPS32 core between three requesters: an external program loader, the MEM stage (LW/SW) and the IF stage. It clears memory after reset, gives the loader exclusive access while loading, and otherwise arbitrates data against fetch each cycle with a starvation guard. It also suppresses squashed stores and halts fetch on HLT.

## Interface
- DEPTH, 1024, memory words
- AW, 10, word-address width (log2 DEPTH)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch overrides data
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip CLEAR

- clk1  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- ld_en  in  1  loader mode request (level)
- ld_we  in  1  loader write strobe
- ld_addr  in  32  loader word address
- ld_wdata  in  32  loader write data
- d_req  in  1  MEM-stage request
- d_we  in  1  1 = store, 0 = load
- d_kill  in  1  squash store (branch taken)
- d_addr  in  32  data word address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- f_req  in  1  IF-stage request
- f_addr  in  32  fetch word address (PC)
- f_gnt  out  1  fetch accepted this cycle
- f_rvalid  out  1  instruction valid
- halted  in  1  core halted; fetch never granted
- rdata  out  32  shared read data (loader, data, fetch)
- ld_rvalid  out  1  loader read data valid
- ready  out  1  high in RUN
- addr_err  out  1  one-cycle pulse on granted access with address >= DEPTH

## Operation
- States: CLEAR, RUN, LOAD. Reset → CLEAR (or RUN if CLEAR_ON_RESET=0).
- CLEAR: internal counter writes 0 to address 0..DEPTH-1, one word per cycle; after writing DEPTH-1 → RUN. No grants in CLEAR; ld_en ignored.
- RUN: ld_en=1 → LOAD next cycle. Otherwise one of data/fetch granted per cycle. Default priority data > fetch. Starvation counter increments each cycle f_req=1 and f_gnt=0, holding at STARVE_LIMIT; at STARVE_LIMIT fetch wins. Counter clears on f_gnt or f_req=0.
- LOAD: every cycle is a loader access (ld_we=1 write, else read). d_gnt=f_gnt=0. ld_en=0 → RUN next cycle; starvation counter cleared.
- halted=1: f_gnt=0, starvation counter held at 0; data port still served.
- Granted store with d_kill=1: no memory write, d_gnt still asserted.
- Address >= DEPTH (any bit above AW-1 set): write suppressed, read returns 0 with normal rvalid, addr_err pulses.
- Requesters hold req/addr/wdata stable until gnt. An ungranted request carries no state.

## Timing
- Grants are combinational from state, requests and counter in the same cycle.
- Writes commit at the clk1 edge ending the grant cycle.
- Read latency is 1: the rvalid for the granted port is high, with rdata valid, in the cycle after the grant. Exactly one rvalid can be high per cycle.
- Read of an address in the cycle after a write to it returns the new data.
- Reset values: d_gnt, f_gnt, d_rvalid, f_rvalid, ld_rvalid, addr_err, ready = 0; rdata = 0; counter = 0.
- rst mid-operation: an outstanding rvalid is dropped. rdata and rvalids are zero the cycle after reset. CLEAR restarts from address 0.
- CLEAR lasts exactly DEPTH cycles. ready rises in the cycle after the last clear write.
- A LOAD→RUN transition permits a data/fetch grant in the first RUN cycle.

## Structure
- Package mips_mem_pkg: state enum (CLEAR/RUN/LOAD), DEPTH/AW/DW defaults, port-select encoding (LD/DATA/FETCH) used for the registered rvalid steering.
- Sub-module mips_sp_ram: single-port synchronous RAM (we, addr, wdata, registered rdata). No reset on the array. The arbiter holds the FSM, counter, muxes and range check.

## Test plan
- Reset with CLEAR_ON_RESET=1 → ready=0 for 1024 cycles, then 1. Load reads of 0, 512 and 1023 all return 0.
- LOAD: write 0x28010078 to addr 0, then read addr 0 → ld_rvalid one cycle later with rdata=0x28010078. d_gnt and f_gnt stay 0 throughout LOAD.
- RUN with d_req and f_req held high, STARVE_LIMIT=4 → data granted 4 cycles, fetch granted on the 5th, then data again.
- Store 0x82 to addr 121 with d_kill=1, then without d_kill → first load of addr 121 returns the old value, second returns 0x82.
- d_addr=0x400 store then load → memory unchanged, addr_err pulses on each grant, load rdata=0.
- halted=1 with f_req=1 → f_gnt never asserted, data loads still complete. rst asserted during a granted read → no rvalid in the following cycle, state CLEAR.
